// File: rtl/ch_pkg.sv
//------------------------------------------------------------------------------
// Module : ch_pkg
// Shared definitions for the cluster-head advertisement transmit path:
// word width, hop-count sentinel, packet type codes, tx FSM state encoding
// and the header-word pack helper.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ch_pkg;

  localparam int          WORD_WIDTH = 16;
  localparam logic [15:0] HOPS_INF   = 16'hFFFF;
  localparam logic [3:0]  PKT_CH_ADV = 4'h1;
  localparam logic [3:0]  PKT_RELAY  = 4'h2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_ID    = 3'd2,
    S_HOPS  = 3'd3,
    S_QV    = 3'd4,
    S_LIMIT = 3'd5,
    S_CSUM  = 3'd6,
    S_DONE  = 3'd7
  } tx_state_t;

  // Header word layout: {type[15:12], len[11:8], seq[7:0]}
  function automatic logic [15:0] pack_hdr(input logic [3:0] pkt_type,
                                            input logic [3:0] len,
                                            input logic [7:0] seq);
    return {pkt_type, len, seq};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ch_tx_csum.sv
//------------------------------------------------------------------------------
// Module : ch_tx_csum
// Running XOR over every word transferred in a packet. Cleared when a new
// packet is accepted; o_next already folds in the word currently on the bus
// so the checksum word can be loaded on the same edge the last field leaves.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ch_tx_csum #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic [WORD_WIDTH-1:0] i_data,
  output logic [WORD_WIDTH-1:0] o_next
);

  logic [WORD_WIDTH-1:0] r_acc;

  // Accumulate each transferred word; restart from zero on a new packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc ^ i_data;
    end
  end

  assign o_next = r_acc ^ i_data;

endmodule

`default_nettype wire

// File: rtl/ch_adv_tx.sv
//------------------------------------------------------------------------------
// Module : ch_adv_tx
// Cluster-head advertisement transmitter. Serialises {header, ID, hops,
// Q-value, [CH limit], [checksum]} as 16-bit words on a valid/ready stream.
// Build option: define CHKSUM_EN to append an XOR checksum word.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ch_adv_tx #(
  parameter int WORD_WIDTH = 16,
  parameter int SEQ_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_start,
  input  logic                  is_CH,
  input  logic [WORD_WIDTH-1:0] my_ID,
  input  logic [WORD_WIDTH-1:0] my_Hops,
  input  logic [WORD_WIDTH-1:0] my_QValue,
  input  logic [WORD_WIDTH-1:0] HB_CHlimit,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_last,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  tx_skip
);

  import ch_pkg::*;

`ifdef CHKSUM_EN
  localparam bit         HAS_CSUM  = 1'b1;
  localparam logic [3:0] LEN_EXTRA = 4'd1;
`else
  localparam bit         HAS_CSUM  = 1'b0;
  localparam logic [3:0] LEN_EXTRA = 4'd0;
`endif
  localparam logic [3:0] LEN_CH    = 4'd5 + LEN_EXTRA;
  localparam logic [3:0] LEN_RELAY = 4'd4 + LEN_EXTRA;

  tx_state_t             r_state;
  logic [SEQ_WIDTH-1:0]  r_seq;
  logic                  r_is_ch;
  logic [WORD_WIDTH-1:0] r_id;
  logic [WORD_WIDTH-1:0] r_hops;
  logic [WORD_WIDTH-1:0] r_qv;
  logic [WORD_WIDTH-1:0] r_limit;
  logic                  r_valid;
  logic [WORD_WIDTH-1:0] r_data;
  logic                  r_last;
  logic                  r_done;
  logic                  r_skip;

  logic [WORD_WIDTH-1:0] w_hops;
  logic                  w_can_start;
  logic                  w_skip;
  logic                  w_accept;
  logic                  w_xfer;

  // Own hop count plus one, saturating so "no route" stays "no route"
  assign w_hops      = (my_Hops == HOPS_INF) ? HOPS_INF : my_Hops + 16'd1;
  assign w_can_start = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_skip      = !is_CH && (w_hops == HOPS_INF);
  assign w_accept    = tx_start && w_can_start && !w_skip;
  assign w_xfer      = r_valid && tx_ready;

`ifdef CHKSUM_EN
  logic [WORD_WIDTH-1:0] w_csum_next;

  ch_tx_csum #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_csum (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_accept),
    .i_en   (w_xfer),
    .i_data (r_data),
    .o_next (w_csum_next)
  );
`endif

  // Packet sequencer: latches the advert fields and walks the word order
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_seq   <= '0;
      r_is_ch <= 1'b0;
      r_id    <= '0;
      r_hops  <= '0;
      r_qv    <= '0;
      r_limit <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_skip  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_skip <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (tx_start && w_skip) begin
            r_skip <= 1'b1;
          end else if (tx_start) begin
            r_is_ch <= is_CH;
            r_id    <= my_ID;
            r_hops  <= w_hops;
            r_qv    <= my_QValue;
            r_limit <= HB_CHlimit;
            r_state <= S_HDR;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_data  <= pack_hdr(is_CH ? PKT_CH_ADV : PKT_RELAY,
                                is_CH ? LEN_CH : LEN_RELAY,
                                r_seq[7:0]);
          end
        end
        S_HDR: if (w_xfer) begin
          r_state <= S_ID;
          r_data  <= r_id;
        end
        S_ID: if (w_xfer) begin
          r_state <= S_HOPS;
          r_data  <= r_hops;
        end
        S_HOPS: if (w_xfer) begin
          r_state <= S_QV;
          r_data  <= r_qv;
          r_last  <= !r_is_ch && !HAS_CSUM;
        end
        S_QV: if (w_xfer) begin
          if (r_is_ch) begin
            r_state <= S_LIMIT;
            r_data  <= r_limit;
            r_last  <= !HAS_CSUM;
          end else begin
`ifdef CHKSUM_EN
            r_state <= S_CSUM;
            r_data  <= w_csum_next;
            r_last  <= 1'b1;
`else
            r_state <= S_DONE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b1;
            r_seq   <= r_seq + 1'b1;
`endif
          end
        end
        S_LIMIT: if (w_xfer) begin
`ifdef CHKSUM_EN
          r_state <= S_CSUM;
          r_data  <= w_csum_next;
          r_last  <= 1'b1;
`else
          r_state <= S_DONE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_done  <= 1'b1;
          r_seq   <= r_seq + 1'b1;
`endif
        end
`ifdef CHKSUM_EN
        S_CSUM: if (w_xfer) begin
          r_state <= S_DONE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_done  <= 1'b1;
          r_seq   <= r_seq + 1'b1;
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_valid = r_valid;
  assign tx_data  = r_data;
  assign tx_last  = r_last;
  assign tx_done  = r_done;
  assign tx_skip  = r_skip;
  assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_ch_adv_tx.sv
//------------------------------------------------------------------------------
// Module : tb_ch_adv_tx
// Directed self-checking bench for ch_adv_tx (honours CHKSUM_EN).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ch_adv_tx;

`ifdef CHKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_start = 1'b0;
  logic        is_CH = 1'b0;
  logic [15:0] my_ID = '0;
  logic [15:0] my_Hops = '0;
  logic [15:0] my_QValue = '0;
  logic [15:0] HB_CHlimit = '0;
  logic        tx_ready = 1'b1;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_last;
  logic        busy;
  logic        tx_done;
  logic        tx_skip;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] c_words [0:7];
  logic        c_last  [0:7];
  int          c_n;
  int          c_unstable;
  logic [15:0] exp_w   [0:7];

  ch_adv_tx #(.WORD_WIDTH(16), .SEQ_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .is_CH(is_CH),
    .my_ID(my_ID), .my_Hops(my_Hops), .my_QValue(my_QValue),
    .HB_CHlimit(HB_CHlimit), .tx_ready(tx_ready), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_last(tx_last), .busy(busy),
    .tx_done(tx_done), .tx_skip(tx_skip)
  );

  always #5 clk = ~clk;

  // Pulse tx_start for one cycle; returns at the negedge after acceptance
  task automatic start_pkt(input logic ch, input logic [15:0] id,
                           input logic [15:0] hops, input logic [15:0] q,
                           input logic [15:0] lim);
    @(negedge clk);
    is_CH = ch; my_ID = id; my_Hops = hops; my_QValue = q; HB_CHlimit = lim;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Gather transferred words until tx_last transfers (bounded); returns in the cycle after
  task automatic collect(input bit toggle);
    bit          ph;
    bit          stalled;
    bit          fin;
    logic [15:0] held;
    logic        held_last;
    c_n = 0; c_unstable = 0; ph = 1'b0; stalled = 1'b0; fin = 1'b0;
    held = '0; held_last = 1'b0;
    for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
      tx_ready = toggle ? ph : 1'b1;
      ph = ~ph;
      if (stalled && !tx_valid) c_unstable++;
      if (tx_valid) begin
        if (stalled && (tx_data !== held || tx_last !== held_last)) c_unstable++;
        if (tx_ready) begin
          if (c_n < 8) begin
            c_words[c_n] = tx_data;
            c_last[c_n]  = tx_last;
          end
          c_n++;
          stalled = 1'b0;
          if (tx_last) fin = 1'b1;
        end else begin
          stalled = 1'b1; held = tx_data; held_last = tx_last;
        end
      end
      @(negedge clk);
    end
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({tx_valid, tx_data, tx_last, busy, tx_done, tx_skip} !== 21'd0) begin
      n_err++; $display("FAIL reset_outputs: got v=%b d=%h l=%b b=%b dn=%b sk=%b, want all 0",
                        tx_valid, tx_data, tx_last, busy, tx_done, tx_skip);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({tx_valid, busy} !== 2'b00) begin
      n_err++; $display("FAIL reset_release_idle: got v=%b b=%b, want 0 0", tx_valid, busy);
    end
  endtask

  task automatic test_ch_advert();
    exp_w[0] = (CS != 0) ? 16'h1600 : 16'h1500;
    exp_w[1] = 16'h000C; exp_w[2] = 16'h0001; exp_w[3] = 16'h4000; exp_w[4] = 16'h0003;
    exp_w[5] = 16'h560E;
    start_pkt(1'b1, 16'd12, 16'd0, 16'h4000, 16'd3);
    n_cmp++; if (busy !== 1'b1) begin
      n_err++; $display("FAIL ch_busy: got %b want 1", busy);
    end
    collect(1'b0);
    n_cmp++; if (c_n !== 5 + CS) begin
      n_err++; $display("FAIL ch_count: got %0d want %0d", c_n, 5 + CS);
    end
    for (int i = 0; i < 5 + CS && i < c_n; i++) begin
      n_cmp++; if (c_words[i] !== exp_w[i] || c_last[i] !== (i == 4 + CS)) begin
        n_err++; $display("FAIL ch_word%0d: got %h last=%b want %h last=%b",
                          i, c_words[i], c_last[i], exp_w[i], (i == 4 + CS));
      end
    end
    n_cmp++; if ({tx_done, busy, tx_valid} !== 3'b100) begin
      n_err++; $display("FAIL ch_done: got done=%b busy=%b v=%b want 1 0 0", tx_done, busy, tx_valid);
    end
    @(negedge clk);
    n_cmp++; if (tx_done !== 1'b0) begin
      n_err++; $display("FAIL ch_done_pulse: got %b want 0", tx_done);
    end
  endtask

  task automatic test_relay_stall();
    exp_w[0] = (CS != 0) ? 16'h2501 : 16'h2401;
    exp_w[1] = 16'h0017; exp_w[2] = 16'h0003; exp_w[3] = 16'h3000; exp_w[4] = 16'h1515;
    start_pkt(1'b0, 16'd23, 16'd2, 16'h3000, 16'd9);
    // change inputs mid-packet; latched copy must be used
    my_ID = 16'hDEAD; my_QValue = 16'hBEEF;
    collect(1'b1);
    n_cmp++; if (c_n !== 4 + CS) begin
      n_err++; $display("FAIL relay_count: got %0d want %0d", c_n, 4 + CS);
    end
    for (int i = 0; i < 4 + CS && i < c_n; i++) begin
      n_cmp++; if (c_words[i] !== exp_w[i] || c_last[i] !== (i == 3 + CS)) begin
        n_err++; $display("FAIL relay_word%0d: got %h last=%b want %h last=%b",
                          i, c_words[i], c_last[i], exp_w[i], (i == 3 + CS));
      end
    end
    n_cmp++; if (c_unstable !== 0) begin
      n_err++; $display("FAIL relay_stall_stable: got %0d changes want 0", c_unstable);
    end
    n_cmp++; if (tx_done !== 1'b1) begin
      n_err++; $display("FAIL relay_done: got %b want 1", tx_done);
    end
  endtask

  task automatic test_skip();
    logic [15:0] hv [0:1];
    hv[0] = 16'hFFFE; hv[1] = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      start_pkt(1'b0, 16'd23, hv[k], 16'h3000, 16'd0);
      n_cmp++; if ({tx_skip, tx_valid, busy} !== 3'b100) begin
        n_err++; $display("FAIL skip_%h: got sk=%b v=%b b=%b want 1 0 0", hv[k], tx_skip, tx_valid, busy);
      end
      @(negedge clk);
      n_cmp++; if ({tx_skip, tx_valid} !== 2'b00) begin
        n_err++; $display("FAIL skip_pulse_%h: got sk=%b v=%b want 0 0", hv[k], tx_skip, tx_valid);
      end
    end
    // seq still 2 after the two skipped requests
    start_pkt(1'b0, 16'd23, 16'h0005, 16'h3000, 16'd0);
    collect(1'b0);
    n_cmp++; if (c_words[0] !== ((CS != 0) ? 16'h2502 : 16'h2402)) begin
      n_err++; $display("FAIL skip_seq_hdr: got %h want %h", c_words[0], (CS != 0) ? 16'h2502 : 16'h2402);
    end
    n_cmp++; if (c_words[2] !== 16'h0006) begin
      n_err++; $display("FAIL hops_plus1: got %h want 0006", c_words[2]);
    end
    // a CH advert with no route is still sent, hops saturated
    start_pkt(1'b1, 16'd7, 16'hFFFF, 16'h1000, 16'd2);
    collect(1'b0);
    n_cmp++; if (c_n !== 5 + CS || c_words[0] !== ((CS != 0) ? 16'h1603 : 16'h1503) || c_words[2] !== 16'hFFFF) begin
      n_err++; $display("FAIL ch_hops_sat: got n=%0d hdr=%h hops=%h want n=%0d hops=FFFF", c_n, c_words[0], c_words[2], 5 + CS);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] hdr;
    logic [3:0]  len;
    logic [7:0]  s;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    len = 4'd5 + 4'(CS);
    start_pkt(1'b1, 16'd12, 16'd0, 16'h4000, 16'd3);
    for (int p = 0; p < 257; p++) begin
      s = p[7:0];
      hdr = {4'h1, len, s};
      if (p > 0) begin
        n_cmp++; if (tx_valid !== 1'b1) begin
          n_err++; $display("FAIL b2b_gap%0d: got valid=%b want 1", p, tx_valid);
        end
      end
      collect(1'b0);
      n_cmp++; if (c_words[0] !== hdr || c_n !== 5 + CS) begin
        n_err++; $display("FAIL b2b_hdr%0d: got %h n=%0d want %h n=%0d", p, c_words[0], c_n, hdr, 5 + CS);
      end
      n_cmp++; if (tx_done !== 1'b1) begin
        n_err++; $display("FAIL b2b_done%0d: got %b want 1", p, tx_done);
      end
      if (p < 256) begin
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    start_pkt(1'b1, 16'd12, 16'd0, 16'h4000, 16'd3);
    repeat (3) @(negedge clk);
    n_cmp++; if (tx_data !== 16'h4000 || tx_valid !== 1'b1) begin
      n_err++; $display("FAIL mid_qv: got %h v=%b want 4000 1", tx_data, tx_valid);
    end
    rst = 1'b1;
    #1;
    n_cmp++; if ({tx_valid, busy, tx_last, tx_data} !== 19'd0) begin
      n_err++; $display("FAIL mid_reset: got v=%b b=%b l=%b d=%h want 0", tx_valid, busy, tx_last, tx_data);
    end
    @(negedge clk);
    rst = 1'b0;
    start_pkt(1'b1, 16'd12, 16'd0, 16'h4000, 16'd3);
    n_cmp++; if (tx_valid !== 1'b1 || tx_data !== ((CS != 0) ? 16'h1600 : 16'h1500)) begin
      n_err++; $display("FAIL post_reset_hdr: got v=%b %h want 1 %h", tx_valid, tx_data, (CS != 0) ? 16'h1600 : 16'h1500);
    end
    collect(1'b0);
    n_cmp++; if (c_n !== 5 + CS) begin
      n_err++; $display("FAIL post_reset_count: got %0d want %0d", c_n, 5 + CS);
    end
  endtask

  initial begin
    test_reset();
    test_ch_advert();
    test_relay_stall();
    test_skip();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
